// File: rtl/qbert_jump_animator.sv
// Qbert jump animator: converts a one-shot jump command into a frame-paced
// XY trajectory with a parabolic lift. A bad jump lands and then falls to
// the floor, where the sprite sits knocked out until a new position is
// loaded. All motion advances on frame ticks only, so the sprite never
// tears mid-frame.
module qbert_jump_animator #(
  parameter int JUMP_DX  = 60,
  parameter int JUMP_DY  = 90,
  parameter int N_FRAMES = 6,
  parameter int ARC_STEP = 8,
  parameter int FALL_DY  = 16,
  parameter int X_MAX    = 799,
  parameter int Y_MAX    = 479
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iNewFrame,
  input  logic        iLoad,
  input  logic [20:0] iXY0,
  input  logic        iStart,
  input  logic [2:0]  iJump,
  input  logic        iBad,
  input  logic        iPause,
  output logic [20:0] oXY_qb,
  output logic        oBusy,
  output logic        oDone,
  output logic        oKO,
  output logic [2:0]  oState
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_JUMP = 3'd2;
  localparam logic [2:0] ST_FALL = 3'd3;
  localparam logic [2:0] ST_KO   = 3'd4;

  localparam int KW = $clog2(N_FRAMES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_FRAMES);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_ZERO = KW'(0);

  localparam logic signed [11:0] DX_TOT    = 12'(JUMP_DX);
  localparam logic signed [11:0] DY_TOT    = 12'(JUMP_DY);
  localparam logic signed [11:0] DX_STEP   = 12'(JUMP_DX / N_FRAMES);
  localparam logic signed [11:0] DY_STEP   = 12'(JUMP_DY / N_FRAMES);
  localparam logic signed [11:0] FALL_STEP = 12'(FALL_DY);
  localparam logic signed [11:0] XMAX_P    = 12'(X_MAX);
  localparam logic signed [11:0] YMAX_P    = 12'(Y_MAX);
  localparam logic signed [12:0] YMAX_W    = 13'(Y_MAX);
  localparam logic [12:0]        ARC_W     = 13'(ARC_STEP);

  // State and datapath registers; pos is 12-bit signed so moves past the
  // top/left edge go negative instead of wrapping.
  logic [2:0]           state_r, state_s;
  logic signed [11:0]   pos_x_r, pos_x_s, pos_y_r, pos_y_s;
  logic signed [11:0]   tgt_x_r, tgt_x_s, tgt_y_r, tgt_y_s;
  logic [KW-1:0]        k_r, k_s;
  logic                 left_r, left_s, up_r, up_s, bad_r, bad_s;
  logic                 start_d_r;
  logic                 tick_s, start_edge_s, done_s;
  logic signed [11:0]   step_x_s, step_y_s;
  logic [KW-1:0]        kmin_s;
  logic signed [12:0]   lift_s, y_ext_s, y_arc_s;
  logic [10:0]          x_out_s;
  logic [9:0]           y_out_s;

  assign tick_s       = iNewFrame & ~iPause;
  assign start_edge_s = iStart & ~start_d_r;
  assign step_x_s     = left_r ? (pos_x_r - DX_STEP) : (pos_x_r + DX_STEP);
  assign step_y_s     = up_r   ? (pos_y_r - DY_STEP) : (pos_y_r + DY_STEP);
  assign oState       = state_r;

  // Next-state and next-position logic of the jump sequencer.
  always_comb begin
    state_s = state_r;
    pos_x_s = pos_x_r;
    pos_y_s = pos_y_r;
    tgt_x_s = tgt_x_r;
    tgt_y_s = tgt_y_r;
    k_s     = k_r;
    left_s  = left_r;
    up_s    = up_r;
    bad_s   = bad_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        k_s = K_ZERO;
        if (iLoad) begin
          pos_x_s = {1'b0, iXY0[20:10]};
          pos_y_s = {2'b00, iXY0[9:0]};
        end else if (start_edge_s && iJump[2]) begin
          left_s  = iJump[0];
          up_s    = iJump[1];
          bad_s   = iBad;
          tgt_x_s = iJump[0] ? (pos_x_r - DX_TOT) : (pos_x_r + DX_TOT);
          tgt_y_s = iJump[1] ? (pos_y_r - DY_TOT) : (pos_y_r + DY_TOT);
          state_s = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (tick_s) begin
          pos_x_s = step_x_s;
          pos_y_s = step_y_s;
          k_s     = K_ONE;
          state_s = ST_JUMP;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_JUMP: begin
        if (tick_s) begin
          if ((k_r + K_ONE) == K_LAST) begin
            // Snap to the target so integer steps never leave a residue.
            pos_x_s = tgt_x_r;
            pos_y_s = tgt_y_r;
            k_s     = K_ZERO;
            if (bad_r) begin
              state_s = ST_FALL;
            end else begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end
          end else begin
            pos_x_s = step_x_s;
            pos_y_s = step_y_s;
            k_s     = k_r + K_ONE;
          end
        end else begin
          state_s = ST_JUMP;
        end
      end
      ST_FALL: begin
        if (tick_s) begin
          if ((pos_y_r + FALL_STEP) >= YMAX_P) begin
            pos_y_s = YMAX_P;
            state_s = ST_KO;
          end else begin
            pos_y_s = pos_y_r + FALL_STEP;
          end
        end else begin
          state_s = ST_FALL;
        end
      end
      ST_KO: begin
        if (iLoad) begin
          pos_x_s = {1'b0, iXY0[20:10]};
          pos_y_s = {2'b00, iXY0[9:0]};
          state_s = ST_IDLE;
        end else begin
          state_s = ST_KO;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Display position from next-state values: arc lift then clamp to the screen.
  always_comb begin
    kmin_s = (k_s < (K_LAST - k_s)) ? k_s : (K_LAST - k_s);
    if (state_s == ST_JUMP) begin
      lift_s = $signed(ARC_W * 13'(kmin_s));
    end else begin
      lift_s = 13'sd0;
    end
    y_ext_s = {pos_y_s[11], pos_y_s};
    y_arc_s = y_ext_s - lift_s;
    if (y_arc_s < 13'sd0) begin
      y_out_s = 10'd0;
    end else if (y_arc_s > YMAX_W) begin
      y_out_s = 10'(Y_MAX);
    end else begin
      y_out_s = y_arc_s[9:0];
    end
    if (pos_x_s < 12'sd0) begin
      x_out_s = 11'd0;
    end else if (pos_x_s > XMAX_P) begin
      x_out_s = 11'(X_MAX);
    end else begin
      x_out_s = pos_x_s[10:0];
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_r   <= ST_IDLE;
      pos_x_r   <= 12'sd0;
      pos_y_r   <= 12'sd0;
      tgt_x_r   <= 12'sd0;
      tgt_y_r   <= 12'sd0;
      k_r       <= K_ZERO;
      left_r    <= 1'b0;
      up_r      <= 1'b0;
      bad_r     <= 1'b0;
      start_d_r <= 1'b0;
      oXY_qb    <= 21'd0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oKO       <= 1'b0;
    end else begin
      state_r   <= state_s;
      pos_x_r   <= pos_x_s;
      pos_y_r   <= pos_y_s;
      tgt_x_r   <= tgt_x_s;
      tgt_y_r   <= tgt_y_s;
      k_r       <= k_s;
      left_r    <= left_s;
      up_r      <= up_s;
      bad_r     <= bad_s;
      start_d_r <= iStart;
      oXY_qb    <= {x_out_s, y_out_s};
      oBusy     <= (state_s != ST_IDLE) && (state_s != ST_KO);
      oDone     <= done_s;
      oKO       <= (state_s == ST_KO);
    end
  end

endmodule

// File: tb/tb_qbert_jump_animator.sv
// Directed self-checking bench for qbert_jump_animator.
module tb_qbert_jump_animator;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iNewFrame = 1'b0;
  logic        iLoad = 1'b0;
  logic [20:0] iXY0 = 21'd0;
  logic        iStart = 1'b0;
  logic [2:0]  iJump = 3'b000;
  logic        iBad = 1'b0;
  logic        iPause = 1'b0;
  logic [20:0] oXY_qb;
  logic        oBusy, oDone, oKO;
  logic [2:0]  oState;

  int n_checks = 0;
  int n_fail = 0;

  qbert_jump_animator dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iNewFrame(iNewFrame), .iLoad(iLoad),
    .iXY0(iXY0), .iStart(iStart), .iJump(iJump), .iBad(iBad), .iPause(iPause),
    .oXY_qb(oXY_qb), .oBusy(oBusy), .oDone(oDone), .oKO(oKO), .oState(oState)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [20:0] xy(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[10:0], yv[9:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_xy(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(oXY_qb[20:10]), 32'(x));
    chk({tag, "_y"}, 32'(oXY_qb[9:0]), 32'(y));
  endtask

  task automatic tick();
    @(negedge iCLK);
    iNewFrame = 1'b1;
    @(negedge iCLK);
    iNewFrame = 1'b0;
  endtask

  task automatic load(input int x, input int y);
    @(negedge iCLK);
    iXY0 = xy(x, y);
    iLoad = 1'b1;
    @(negedge iCLK);
    iLoad = 1'b0;
  endtask

  task automatic start(input logic [2:0] j, input logic bad);
    @(negedge iCLK);
    iJump = j;
    iBad = bad;
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    iBad = 1'b0;
  endtask

  int exp_y[6] = '{107, 114, 121, 144, 167, 190};

  initial begin
    // Reset values
    #12;
    chk("rst_xy", 32'(oXY_qb), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_ko", 32'(oKO), 32'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;

    // Load, then an invalid jump request is ignored
    load(400, 100);
    chk_xy("load", 400, 100);
    start(3'b000, 1'b0);
    chk("invalid_start_state", 32'(oState), 32'd0);

    // Down-right jump with arc
    start(3'b100, 1'b0);
    chk("arm_state", 32'(oState), 32'd1);
    chk("arm_busy", 32'(oBusy), 32'd1);
    chk_xy("arm_hold", 400, 100);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_xy($sformatf("dr_t%0d", i), 400 + 10 * i, exp_y[i-1]);
      chk($sformatf("dr_done_t%0d", i), 32'(oDone), (i == 6) ? 32'd1 : 32'd0);
    end
    chk("dr_busy_end", 32'(oBusy), 32'd0);
    @(negedge iCLK);
    chk("dr_done_pulse", 32'(oDone), 32'd0);

    // Up-left from near the corner clamps at 0
    load(20, 10);
    start(3'b111, 1'b0);
    tick();
    chk_xy("ul_t1", 10, 0);
    for (int i = 2; i <= 6; i++) tick();
    chk_xy("ul_end", 0, 0);
    chk("ul_done", 32'(oDone), 32'd1);

    // Bad jump: land off-map, fall to the floor, KO
    load(400, 400);
    start(3'b100, 1'b1);
    tick();
    chk_xy("bad_t1", 410, 407);
    for (int i = 2; i <= 6; i++) tick();
    chk_xy("bad_land", 460, 479);
    chk("bad_no_done", 32'(oDone), 32'd0);
    chk("bad_fall_state", 32'(oState), 32'd3);
    chk("bad_fall_busy", 32'(oBusy), 32'd1);
    tick();
    chk_xy("ko_xy", 460, 479);
    chk("ko_flag", 32'(oKO), 32'd1);
    chk("ko_state", 32'(oState), 32'd4);
    chk("ko_busy", 32'(oBusy), 32'd0);
    start(3'b100, 1'b0);
    chk("ko_start_ignored", 32'(oState), 32'd4);
    load(100, 200);
    chk("ko_cleared", 32'(oKO), 32'd0);
    chk("ko_to_idle", 32'(oState), 32'd0);
    chk_xy("ko_reload", 100, 200);

    // Tick coincident with load in IDLE: load wins
    @(negedge iCLK);
    iXY0 = xy(100, 100);
    iLoad = 1'b1;
    iNewFrame = 1'b1;
    @(negedge iCLK);
    iLoad = 1'b0;
    iNewFrame = 1'b0;
    chk_xy("load_vs_tick", 100, 100);

    // Pause stretches the jump; start edges while busy are ignored
    start(3'b100, 1'b0);
    for (int i = 1; i <= 3; i++) tick();
    chk_xy("p_t3", 130, 121);
    iPause = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    chk_xy("p_frozen", 130, 121);
    start(3'b111, 1'b0);
    chk("p_busy_start", 32'(oState), 32'd2);
    iPause = 1'b0;
    tick();
    tick();
    chk("p_t5_done", 32'(oDone), 32'd0);
    chk_xy("p_t5", 150, 167);
    tick();
    chk_xy("p_end", 160, 190);
    chk("p_done", 32'(oDone), 32'd1);

    // Asynchronous reset mid-jump (k=3)
    load(400, 100);
    start(3'b100, 1'b0);
    for (int i = 1; i <= 3; i++) tick();
    chk_xy("r_pre", 430, 121);
    #2;
    iRST_n = 1'b0;
    #1;
    chk("r_xy", 32'(oXY_qb), 32'd0);
    chk("r_busy", 32'(oBusy), 32'd0);
    chk("r_state", 32'(oState), 32'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    chk("r_no_move", 32'(oXY_qb), 32'd0);
    chk("r_no_done", 32'(oDone), 32'd0);
    load(200, 200);
    start(3'b100, 1'b0);
    tick();
    chk_xy("r_restart", 210, 207);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
